uart_rx_fsm: RTL and testbench
==============================

# uart_rx_fsm

Oversampling UART receiver: detects a start bit on `rx_in`, samples 8 data bits LSB-first, an optional parity bit and one stop bit, then presents the byte on `p_data` with a one-cycle `data_valid` strobe. It is the receive-side counterpart of the UART transmit FSM/serializer path. It sits in the UART clock domain, feeding the RX data synchronizer toward the system clock domain.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `clk` input 1: UART oversampling clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx_in` input 1: serial line, idle high; already synchronized externally.
- `prescale` input 6: oversampling ratio; legal values 8, 16, 32; any other value is treated as 8.
- `PAR_EN` input 1: 1 = parity bit present after data.
- `PAR_TYP` input 1: 0 = even, 1 = odd.
- `p_data` output DATA_WIDTH: last good byte; reset 0.
- `data_valid` output 1: one-cycle strobe, good frame; reset 0.
- `par_err` output 1: one-cycle strobe, parity mismatch; reset 0.
- `stp_err` output 1: one-cycle strobe, stop bit sampled 0; reset 0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- `prescale`, `PAR_EN`, `PAR_TYP` latched on the IDLE→START transition; changes mid-frame are ignored until the next frame.
- `edge_cnt` counts 0..prescale-1 per bit period and wraps to 0. `bit_cnt` counts data bits 0..DATA_WIDTH-1.
- Sample point: `edge_cnt` == prescale/2 (see Configuration). The bit value is evaluated at `edge_cnt` == prescale-1.
- IDLE: `rx_in`==0 → START, with `edge_cnt` cleared to 0. Otherwise stay in IDLE.
- START: sampled bit 1 (glitch) → IDLE with no strobe. Sampled bit 0 → DATA at end of bit.
- DATA: shift the sampled bit into the shift register LSB-first. After bit DATA_WIDTH-1, go to PARITY if latched `PAR_EN`, otherwise go to STOP.
- PARITY: the expected value is XOR of the data bits, inverted when `PAR_TYP`=1. A mismatch sets an internal error flag. Always → STOP.
- STOP: at end of bit, → IDLE. Raise exactly one strobe in the next cycle:
  - sampled 0 → `stp_err`;
  - else error flag set → `par_err`;
  - else → `data_valid` with `p_data` updated in the same cycle.
- `p_data` changes only with `data_valid`. Errored frames leave it unchanged.
- At most one of `data_valid`/`par_err`/`stp_err` is high in any cycle.
- Reset mid-frame: immediate return to IDLE, counters, shift register and error flag cleared, no strobe.

## Timing
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1) × prescale cycles, counted from the first cycle IDLE sees `rx_in`=0.
- Start detection latency: one cycle after the falling edge is visible on `rx_in`.
- Strobe latency: one cycle after `edge_cnt` reaches prescale-1 in STOP.
- Back-to-back frames: IDLE is entered on the strobe cycle. A start bit whose falling edge arrives then is detected without loss; nominal re-sync slip is ≤1 cycle per frame.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit is the 2-of-3 majority of samples at `edge_cnt` = prescale/2-1, prescale/2 and prescale/2+1.
- `UART_RX_MAJORITY_EN` undefined: single sample at `edge_cnt` = prescale/2, and the two extra sample registers are removed.
- Frame timing and strobes are identical in both builds.

## Structure
- Shared package `uart_pkg`: FSM state encoding (3-bit localparams), legal prescale constants, the `PAR_TYP` encoding constants.
- Sub-module `uart_rx_sampler`: owns `edge_cnt`, sample registers and the majority vote. Outputs `sampled_bit`, `bit_end` (edge_cnt == prescale-1) and an `edge_cnt` clear input driven by the FSM.
- The top level holds the FSM, `bit_cnt`, shift register, parity check and output registers.

## Test plan
- prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 → single `data_valid` pulse, `p_data`=0xA5, no error strobes, strobe 88 cycles after start edge.
- prescale=16, PAR_EN=1, PAR_TYP=1, byte 0x3C sent with parity bit 0 (wrong) → `par_err` one cycle, `data_valid` stays 0, `p_data` keeps its previous value.
- prescale=32, PAR_EN=0, byte 0x5A with stop bit driven 0 → `stp_err` one cycle, no `data_valid`; a following clean 0x11 frame → `data_valid`, `p_data`=0x11.
- prescale=16, `rx_in` low for 3 cycles then high → FSM back to IDLE after START, no strobe. With `UART_RX_MAJORITY_EN`, a 1-cycle low pulse at the centre of a data bit that is 1 → byte received correctly.
- prescale=8, PAR_EN=0, back-to-back 0x01 then 0xFF with no idle gap → two `data_valid` pulses 80 cycles apart, values 0x01 then 0xFF.
- `rst` asserted for 1 cycle during DATA bit 4 of frame 0xC3 → all outputs 0 immediately, no strobe. The next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, legal oversampling
// ratios and parity-type encoding.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } rx_state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Anything other than 16 or 32 falls back to x8 oversampling.
  function automatic logic [5:0] legal_prescale(input logic [5:0] ps);
    case (ps)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timer and line sampler for the UART receiver.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around mid-bit instead of one sample.
module uart_rx_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic       cnt_clr,
  output logic       sampled_bit,
  output logic       bit_end
);

  logic [5:0] edge_cnt;
  logic [5:0] half;

  assign half    = {1'b0, prescale[5:1]};
  assign bit_end = (edge_cnt == prescale - 6'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      edge_cnt <= '0;
    else if (cnt_clr || bit_end)
      edge_cnt <= '0;
    else
      edge_cnt <= edge_cnt + 6'd1;
  end

`ifdef UART_RX_MAJORITY_EN
  logic samp_early, samp_mid, samp_late;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_early <= 1'b1;
      samp_mid   <= 1'b1;
      samp_late  <= 1'b1;
    end else begin
      if (edge_cnt == half - 6'd1) samp_early <= rx_in;
      if (edge_cnt == half)        samp_mid   <= rx_in;
      if (edge_cnt == half + 6'd1) samp_late  <= rx_in;
    end
  end

  assign sampled_bit = (samp_early & samp_mid) | (samp_early & samp_late) |
                       (samp_mid & samp_late);
`else
  logic samp_mid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      samp_mid <= 1'b1;
    else if (edge_cnt == half)
      samp_mid <= rx_in;
  end

  assign sampled_bit = samp_mid;
`endif

endmodule

// File: rtl/uart_rx_fsm.sv
// Oversampling UART receiver: start/data/parity/stop framing FSM, shift register,
// parity check and one-cycle result strobes.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t             state, state_next;
  logic [5:0]            ps_q;
  logic                  par_en_q, par_typ_q;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  err_q;

  logic sampled_bit, bit_end, cnt_clr;
  logic load_cfg, shift_en, par_chk, finish;
  logic last_bit, par_exp;

  assign cnt_clr  = (state == IDLE);
  assign last_bit = (bit_cnt == BCW'(DATA_WIDTH - 1));
  assign par_exp  = (^shift_q) ^ (par_typ_q == PAR_ODD);

  uart_rx_sampler u_sampler (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (ps_q),
    .cnt_clr     (cnt_clr),
    .sampled_bit (sampled_bit),
    .bit_end     (bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_cfg   = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_in) begin
          state_next = START;
          load_cfg   = 1'b1;
        end
      end
      START: begin
        if (bit_end) state_next = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (last_bit) state_next = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_chk    = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame configuration is frozen at start detection so mid-frame changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q      <= PRESCALE_8;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      bit_cnt   <= '0;
      shift_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (load_cfg) begin
        ps_q      <= legal_prescale(prescale);
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        bit_cnt   <= '0;
        err_q     <= 1'b0;
      end
      if (shift_en) begin
        shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
        bit_cnt <= last_bit ? '0 : bit_cnt + BCW'(1);
      end
      if (par_chk && (sampled_bit != par_exp)) err_q <= 1'b1;
    end
  end

  // Stop-bit error takes priority over parity error; p_data only moves on a good frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (finish) begin
        if (!sampled_bit) begin
          stp_err <= 1'b1;
        end else if (err_q) begin
          par_err <= 1'b1;
        end else begin
          data_valid <= 1'b1;
          p_data     <= shift_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: directed frames push expected strobes,
// a negedge monitor pops and checks them. UART_RX_MAJORITY_EN adds a glitch test.
`timescale 1ns/1ps
module tb_uart_rx_fsm;

  localparam int DW = 8;
  localparam int K_VALID = 0;
  localparam int K_PAR   = 1;
  localparam int K_STP   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [5:0]    prescale;
  logic          PAR_EN, PAR_TYP;
  logic [DW-1:0] p_data;
  logic          data_valid, par_err, stp_err;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    int          start;
    int          lat_min;
    int          lat_max;
  } exp_t;

  exp_t       sb[$];
  int         strobe_cyc[$];
  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  int         strobe_seen = 0;
  int         seen_before;
  logic [7:0] model_pdata = 8'h00;

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual >= lo && actual <= hi) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
  endtask

  // Monitor: every strobe must match the oldest expectation in the scoreboard.
  initial begin
    exp_t e;
    int   kind;
    forever begin
      @(negedge clk);
      if (data_valid || par_err || stp_err) begin
        strobe_seen++;
        strobe_cyc.push_back(cyc);
        kind = data_valid ? K_VALID : (par_err ? K_PAR : K_STP);
        checkOutput("strobe_onehot", 32'(data_valid) + 32'(par_err) + 32'(stp_err), 1);
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_strobe: got kind %0d at cycle %0d, expected none",
                   kind, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("strobe_kind", kind, e.kind);
          checkOutput("p_data", p_data, e.data);
          checkRange("strobe_latency", cyc - e.start, e.lat_min, e.lat_max);
        end
      end
    end
  end

  task automatic driveBit(input logic b, input bit glitch, input int ps);
    rx_in = b;
    if (glitch) begin
      repeat (ps / 2 + 1) @(negedge clk);
      rx_in = ~b;
      @(negedge clk);
      rx_in = b;
      repeat (ps - ps / 2 - 2) @(negedge clk);
    end else begin
      repeat (ps) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame; ps_eff is the bit length the receiver should use for ps_drive.
  task automatic applyStimulus(input logic [5:0] ps_drive, input int ps_eff,
                               input logic par_en, input logic par_typ,
                               input logic [7:0] data, input logic par_bit,
                               input logic stop_bit, input int exp_kind,
                               input int b2b, input int glitch_bit, input int abort_bit);
    exp_t e;
    int   flen;
    flen = (10 + int'(par_en)) * ps_eff;
    if (abort_bit < 0) begin
      e.kind    = exp_kind;
      e.data    = (exp_kind == K_VALID) ? data : model_pdata;
      e.start   = cyc + 1;
      e.lat_min = flen;
      e.lat_max = flen + b2b;
      sb.push_back(e);
      if (exp_kind == K_VALID) model_pdata = data;
    end
    rx_in    = 1'b0;
    prescale = ps_drive;
    PAR_EN   = par_en;
    PAR_TYP  = par_typ;
    repeat (ps_eff) @(negedge clk);
    prescale = ~ps_drive;
    PAR_EN   = ~par_en;
    PAR_TYP  = ~par_typ;
    for (int i = 0; i < DW; i++) begin
      if (i == abort_bit) begin
        rx_in = data[i];
        repeat (ps_eff / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_p_data", p_data, 0);
        checkOutput("abort_data_valid", data_valid, 0);
        checkOutput("abort_par_err", par_err, 0);
        checkOutput("abort_stp_err", stp_err, 0);
        model_pdata = 8'h00;
        @(negedge clk);
        rst   = 1'b0;
        rx_in = 1'b1;
        return;
      end
      driveBit(data[i], (glitch_bit == i), ps_eff);
    end
    if (par_en) driveBit(par_bit, 1'b0, ps_eff);
    driveBit(stop_bit, 1'b0, ps_eff);
    rx_in = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    rx_in    = 1'b1;
    prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_p_data", p_data, 0);
    checkOutput("reset_data_valid", data_valid, 0);
    checkOutput("reset_par_err", par_err, 0);
    checkOutput("reset_stp_err", stp_err, 0);
    rst = 1'b0;
    idle(10);

    // 0xA5 even parity (4 ones -> parity 0), x8: good frame, 88-cycle latency
    applyStimulus(6'd8, 8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, K_VALID, 0, -1, -1);
    idle(20);
    // 0x3C odd parity needs 1, sent 0 -> parity error, p_data stays 0xA5
    applyStimulus(6'd16, 16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, K_PAR, 0, -1, -1);
    idle(40);
    // x32 no parity, stop bit low -> stop error; then clean 0x11
    applyStimulus(6'd32, 32, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, K_STP, 0, -1, -1);
    idle(80);
    applyStimulus(6'd32, 32, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, K_VALID, 0, -1, -1);
    idle(80);

    // 3-cycle start glitch at x16 must be rejected silently
    seen_before = strobe_seen;
    prescale = 6'd16;
    PAR_EN   = 1'b0;
    rx_in    = 1'b0;
    repeat (3) @(negedge clk);
    idle(60);
    checkOutput("start_glitch_strobes", strobe_seen - seen_before, 0);

`ifdef UART_RX_MAJORITY_EN
    // 1-cycle low pulse in the middle of data bit 0 (a 1) is outvoted
    applyStimulus(6'd16, 16, 1'b0, 1'b0, 8'hB7, 1'b0, 1'b1, K_VALID, 0, 0, -1);
    idle(40);
`endif

    // illegal prescale 12 behaves as x8; 0x96 odd parity -> parity bit 1
    applyStimulus(6'd12, 8, 1'b1, 1'b1, 8'h96, 1'b1, 1'b1, K_VALID, 0, -1, -1);
    idle(20);

    // back-to-back x8 frames with no idle gap
    applyStimulus(6'd8, 8, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, K_VALID, 0, -1, -1);
    applyStimulus(6'd8, 8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, K_VALID, 1, -1, -1);
    idle(20);
    checkOutput("b2b_strobe_count", strobe_cyc.size() >= 2, 1);
    if (strobe_cyc.size() >= 2)
      checkRange("b2b_spacing", strobe_cyc[$] - strobe_cyc[$-1], 80, 81);

    // reset mid-frame during data bit 4 of 0xC3, then clean 0x7E (6 ones -> even parity 0)
    seen_before = strobe_seen;
    applyStimulus(6'd8, 8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, K_VALID, 0, -1, 4);
    idle(100);
    checkOutput("abort_strobes", strobe_seen - seen_before, 0);
    applyStimulus(6'd8, 8, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b1, K_VALID, 0, -1, -1);

    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    idle(10);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
